// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite draw scheduler and the sprite drawer.
package sprite_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_DRAW   = 2'd2,
    S_ACK    = 2'd3
  } sched_state_e;

  localparam int COORD_W     = 10;
  localparam int SPRITE_SIZE = 31;

  // Ring index base+off, wrapped by explicit compare (off < n, base < n).
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr, wrapping.
module rr_arbiter
  import sprite_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Scan the ring from the far end so the index closest to ptr wins last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[rr_wrap(int'(ptr), k, N)]) begin
        any = 1'b1;
        idx = IW'(rr_wrap(int'(ptr), k, N));
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Shares one sprite drawer among NUM_REQ objects: round-robin, once per frame.
module sprite_draw_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 2047
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       frame_start,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       drw_go,
  output logic [COORD_W-1:0]         drw_x,
  output logic [COORD_W-1:0]         drw_y,
  output logic [SEL_W-1:0]           drw_sel,
  input  logic                       drw_done,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       draw_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_e         state_q;
  logic [IW-1:0]        idx_q, ptr_q, win_idx;
  logic                 win_any;
  logic [NUM_REQ-1:0]   served_q, eligible, ack_q;
  logic                 pending_q, go_q, tmo_q;
  logic [CW-1:0]        cnt_q;
  logic [COORD_W-1:0]   x_q, y_q;
  logic [SEL_W-1:0]     sel_q;

  assign eligible = req & ~served_q;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .any      (win_any),
    .idx      (win_idx)
  );

  // Scheduler FSM with capture registers, served mask, pointer and watchdog.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      served_q  <= '0;
      ack_q     <= '0;
      pending_q <= 1'b0;
      go_q      <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      sel_q     <= '0;
    end else begin
      ack_q <= '0;
      // A frame boundary mid-draw is remembered and applied when the draw retires.
      if (frame_start && state_q != S_IDLE) pending_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (frame_start) served_q <= '0;
          if (win_any) begin
            idx_q   <= win_idx;
            x_q     <= req_x[int'(win_idx)*COORD_W +: COORD_W];
            y_q     <= req_y[int'(win_idx)*COORD_W +: COORD_W];
            sel_q   <= req_sel[int'(win_idx)*SEL_W +: SEL_W];
            go_q    <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        // Drawer still shows idle here, so done is not looked at.
        S_LAUNCH: state_q <= S_DRAW;
        S_DRAW: begin
          if (drw_done) begin
            go_q         <= 1'b0;
            ack_q        <= '0;
            ack_q[idx_q] <= 1'b1;
            state_q      <= S_ACK;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            tmo_q        <= 1'b1;
            go_q         <= 1'b0;
            ack_q        <= '0;
            ack_q[idx_q] <= 1'b1;
            state_q      <= S_ACK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ACK: begin
          cnt_q   <= '0;
          ptr_q   <= (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          state_q <= S_IDLE;
          if (pending_q || frame_start) begin
            served_q  <= '0;
            pending_q <= 1'b0;
          end else begin
            served_q[idx_q] <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack          = ack_q;
  assign drw_go       = go_q;
  assign drw_x        = x_q;
  assign drw_y        = y_q;
  assign drw_sel      = sel_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (eligible == '0) && (state_q == S_IDLE) && !pending_q;
  assign draw_timeout = tmo_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: drawer model plus round-robin reference model.
module tb_sprite_draw_scheduler;

  localparam int NR = 4;
  localparam int SW = 2;
  localparam int TO = 2047;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_start;
  logic [NR-1:0] req;
  logic [NR*10-1:0] req_x, req_y;
  logic [NR*SW-1:0] req_sel;
  logic [NR-1:0] ack;
  logic          drw_go;
  logic [9:0]    drw_x, drw_y;
  logic [SW-1:0] drw_sel;
  logic          drw_done;
  logic          busy, frame_done, draw_timeout;

  int total = 0;
  int bad   = 0;

  // reference model: which requesters have been drawn this frame, where to search next
  int      m_ptr;
  bit [3:0] m_served;
  bit      m_pending;

  // drawer model controls
  int dK;
  bit never_done;
  bit go_prev;
  int dcnt;

  sprite_draw_scheduler #(.NUM_REQ(NR), .SEL_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .req(req),
    .req_x(req_x), .req_y(req_y), .req_sel(req_sel), .ack(ack),
    .drw_go(drw_go), .drw_x(drw_x), .drw_y(drw_y), .drw_sel(drw_sel),
    .drw_done(drw_done), .busy(busy), .frame_done(frame_done),
    .draw_timeout(draw_timeout)
  );

  always #5 clk = ~clk;

  // Drawer: idle shows done=1; go rising starts a K-cycle draw; go low returns it to idle.
  always @(posedge clk) begin
    if (!reset_n || !drw_go) begin
      drw_done <= 1'b1;
      dcnt     <= 0;
    end else if (!go_prev) begin
      drw_done <= 1'b0;
      dcnt     <= dK;
    end else if (!never_done && dcnt == 1) begin
      drw_done <= 1'b1;
      dcnt     <= 0;
    end else if (dcnt > 1) begin
      dcnt <= dcnt - 1;
    end
    go_prev <= reset_n && drw_go;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int m_winner(input bit [3:0] r);
    for (int k = 0; k < NR; k++)
      if (r[(m_ptr + k) % NR] && !m_served[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_served = '0; m_pending = 0;
  endtask

  task automatic scramble();
    for (int i = 0; i < NR; i++) begin
      req_x[10*i +: 10]   = 10'($urandom_range(0, 1023));
      req_y[10*i +: 10]   = 10'($urandom_range(0, 1023));
      req_sel[SW*i +: SW] = SW'($urandom_range(0, 3));
    end
  endtask

  // frame_start while the scheduler sits idle
  task automatic fs_idle();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_served = '0;
    m_pending = 0;
  endtask

  int last_go_lat;

  // One complete draw of requester e: capture, hold, ack and model update.
  task automatic do_draw(input int e, input int k, input bit fs_mid, input bit drop, input bit nev);
    int n, done_cyc, lim;
    logic [9:0] ex, ey;
    logic [SW-1:0] es;
    dK = k;
    never_done = nev;
    ex = req_x[10*e +: 10];
    ey = req_y[10*e +: 10];
    es = req_sel[SW*e +: SW];
    n = 0;
    do begin
      tick();
      n++;
    end while (drw_go !== 1'b1 && n < 30);
    last_go_lat = n;
    chk("go_high", drw_go, 1);
    chk("cap_x", drw_x, ex);
    chk("cap_y", drw_y, ey);
    chk("cap_sel", drw_sel, es);
    chk("busy_draw", busy, 1);
    chk("fdone_draw", frame_done, 0);
    scramble();
    if (drop) req[e] = 1'b0;
    lim = nev ? TO + 20 : 60;
    n = 0;
    done_cyc = -1;
    while (n < lim) begin
      tick();
      frame_start = 1'b0;
      n++;
      if (ack !== '0) break;
      if (drw_done === 1'b1 && done_cyc < 0) done_cyc = n;
      if (fs_mid && n == 1) begin
        frame_start = 1'b1;
        m_pending = 1;
      end
    end
    frame_start = 1'b0;
    chk("ack_onehot", ack, 32'(1) << e);
    chk("ack_go_low", drw_go, 0);
    chk("hold_x", drw_x, ex);
    chk("hold_y", drw_y, ey);
    chk("hold_sel", drw_sel, es);
    if (nev) begin
      chk("tmo_window", (n >= TO && n <= TO + 3) ? 1 : 0, 1);
      chk("tmo_flag", draw_timeout, 1);
    end else begin
      chk("ack_after_done", n, done_cyc + 1);
    end
    if (m_pending) begin
      m_served = '0;
      m_pending = 0;
    end else begin
      m_served[e] = 1'b1;
    end
    m_ptr = (e + 1) % NR;
    tick();
    chk("ack_pulse", ack, 0);
  endtask

  initial begin
    int n, w, guard;
    bit seen_go;
    reset_n = 1'b0; frame_start = 1'b0; req = '0;
    req_x = '0; req_y = '0; req_sel = '0;
    dK = 4; never_done = 0;
    m_reset();
    tick(); tick();
    chk("rst_go", drw_go, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", drw_x, 0);
    chk("rst_tmo", draw_timeout, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_fdone", frame_done, 1);

    // single request, fixed position
    req_x[9:0] = 10'd100; req_y[9:0] = 10'd50; req_sel[1:0] = 2'd2;
    req = 4'b0001;
    do_draw(0, 8, 0, 1, 0);
    chk("go_latency", last_go_lat, 1);

    // round robin order 0,1,3 from ptr 0, then quiet until frame_start
    reset_n = 1'b0; tick(); reset_n = 1'b1; m_reset(); tick();
    scramble();
    req = 4'b1011;
    do_draw(0, 3, 0, 0, 0);
    do_draw(1, 5, 0, 0, 0);
    do_draw(3, 2, 0, 0, 0);
    chk("t2_fdone", frame_done, 1);
    seen_go = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (drw_go) seen_go = 1; end
    chk("t2_no_redraw", seen_go, 0);

    // new frame repeats 0,1,3; then from ptr 2 the order is 3,0,1
    fs_idle();
    do_draw(0, 2, 0, 0, 0);
    do_draw(1, 2, 0, 0, 0);
    do_draw(3, 2, 0, 0, 0);
    req = '0; fs_idle();
    req = 4'b0010;
    do_draw(1, 1, 0, 1, 0);
    fs_idle();
    req = 4'b1011;
    do_draw(3, 4, 0, 0, 0);
    do_draw(0, 4, 0, 0, 0);
    do_draw(1, 4, 0, 0, 0);

    // frame boundary during the draw of requester 1: it is drawn again this frame
    req = '0; fs_idle();
    req = 4'b0010;
    do_draw(1, 6, 1, 0, 0);
    chk("t4_model_redraw", m_winner(req), 1);
    do_draw(1, 4, 0, 1, 0);
    chk("t4_fdone", frame_done, 1);

    // reset in the middle of a draw
    req = 4'b0101;
    dK = 10;
    n = 0;
    do begin tick(); n++; end while (drw_go !== 1'b1 && n < 30);
    chk("t5_go", drw_go, 1);
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    chk("t5_go_drop", drw_go, 0);
    chk("t5_ack", ack, 0);
    chk("t5_busy", busy, 0);
    reset_n = 1'b1;
    m_reset();
    do_draw(0, 3, 0, 0, 0);
    do_draw(2, 3, 0, 0, 0);

    // drawer hangs: watchdog aborts, next requester still served
    req = '0; fs_idle();
    req = 4'b0110;
    chk("t6_tmo_clear", draw_timeout, 0);
    do_draw(1, 5, 0, 0, 1);
    do_draw(2, 5, 0, 0, 0);
    chk("t6_tmo_sticky", draw_timeout, 1);

    // randomized frames against the reference model
    for (int r = 0; r < 25; r++) begin
      req = '0;
      fs_idle();
      scramble();
      req = 4'($urandom_range(1, 15));
      guard = 0;
      w = m_winner(req);
      while (w >= 0 && guard < 12) begin
        do_draw(w, $urandom_range(1, 10), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), 0);
        guard++;
        w = m_winner(req);
      end
      tick();
      chk("rnd_fdone", frame_done, 1);
      chk("rnd_idle", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
